// File: rtl/caliptra_axil2apb_bridge.sv
`default_nettype none
// ============================================================================
// caliptra_axil2apb_bridge: AXI4-Lite slave to NUM_SLV-target APB4 master
// bridge with address decode, DECERR/SLVERR responses and a PREADY timeout.
// Revision: 1.0
// ============================================================================
module caliptra_axil2apb_bridge #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_SLV   = 2,
    parameter int unsigned       SLV_AW    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       TIMEOUT   = 255,
    localparam int unsigned      STRB_W    = DATA_W / 8,
    localparam int unsigned      SEL_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic                      core_clk,
    input  logic                      S_AXI_ARESETN,
    input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_W-1:0]         S_AXI_WDATA,
    input  logic [STRB_W-1:0]         S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_W-1:0]         S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [ADDR_W-1:0]         m_apb_paddr,
    output logic [NUM_SLV-1:0]        m_apb_psel,
    output logic                      m_apb_penable,
    output logic                      m_apb_pwrite,
    output logic [DATA_W-1:0]         m_apb_pwdata,
    output logic [STRB_W-1:0]         m_apb_pstrb,
    output logic [2:0]                m_apb_pprot,
    input  logic [NUM_SLV*DATA_W-1:0] m_apb_prdata,
    input  logic [NUM_SLV-1:0]        m_apb_pready,
    input  logic [NUM_SLV-1:0]        m_apb_pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int unsigned UP_LSB      = SLV_AW + SEL_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    state_e              state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [2:0]          prot_q, prot_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [1:0]          resp_q, resp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         tmo_q, tmo_d;

    logic                wr_elig, rd_elig, grant_wr, grant_rd;
    logic [ADDR_W-1:0]   req_addr;
    logic [SEL_W-1:0]    req_idx;
    logic                dec_err;
    logic                sel_ready, sel_err;
    logic [DATA_W-1:0]   sel_rdata;

    // Round-robin: on contention the direction not granted last time wins.
    assign wr_elig  = S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_elig  = S_AXI_ARVALID;
    assign grant_wr = (state_q == S_IDLE) & wr_elig & (~rd_elig | ~last_wr_q);
    assign grant_rd = (state_q == S_IDLE) & rd_elig & (~wr_elig | last_wr_q);

    assign req_addr = grant_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
    assign req_idx  = req_addr[SLV_AW +: SEL_W];
    assign dec_err  = ((req_addr >> UP_LSB) != (BASE_ADDR >> UP_LSB)) ||
                      (32'(req_idx) >= NUM_SLV);

    assign sel_ready = m_apb_pready[idx_q];
    assign sel_err   = m_apb_pslverr[idx_q];
    assign sel_rdata = m_apb_prdata[idx_q*DATA_W +: DATA_W];

    assign S_AXI_AWREADY = grant_wr;
    assign S_AXI_WREADY  = grant_wr;
    assign S_AXI_ARREADY = grant_rd;
    assign S_AXI_BVALID  = (state_q == S_RESP) & is_wr_q;
    assign S_AXI_RVALID  = (state_q == S_RESP) & ~is_wr_q;
    assign S_AXI_BRESP   = resp_q;
    assign S_AXI_RRESP   = resp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign m_apb_paddr   = addr_q;
    assign m_apb_pwrite  = is_wr_q;
    assign m_apb_pwdata  = wdata_q;
    assign m_apb_pstrb   = strb_q;
    assign m_apb_pprot   = prot_q;
    assign m_apb_penable = (state_q == S_ACCESS);

    always_comb begin
        m_apb_psel = '0;
        if ((state_q == S_SETUP) || (state_q == S_ACCESS)) begin
            m_apb_psel[idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (grant_wr || grant_rd) begin
                    last_wr_d = grant_wr;
                    is_wr_d   = grant_wr;
                    addr_d    = req_addr;
                    wdata_d   = grant_wr ? S_AXI_WDATA : '0;
                    strb_d    = grant_wr ? S_AXI_WSTRB : '0;
                    prot_d    = grant_wr ? S_AXI_AWPROT : S_AXI_ARPROT;
                    idx_d     = req_idx;
                    rdata_d   = '0;
                    if (dec_err) begin
                        resp_d  = RESP_DECERR;
                        state_d = S_RESP;
                    end else begin
                        resp_d  = RESP_OKAY;
                        tmo_d   = '0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready) begin
                    resp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d = (sel_err || is_wr_q) ? '0 : sel_rdata;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0) begin
                    // Abandon the target once it has stalled TIMEOUT access cycles.
                    if (tmo_q + 16'd1 == 16'(TIMEOUT)) begin
                        resp_d  = RESP_SLVERR;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            S_RESP: begin
                if ((is_wr_q && S_AXI_BREADY) || (!is_wr_q && S_AXI_RREADY)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_caliptra_axil2apb_bridge.sv
`default_nettype none
// ============================================================================
// tb_caliptra_axil2apb_bridge: vector table, corner sequences and randomized
// transfers against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_caliptra_axil2apb_bridge;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] paddr, pwdata;
    logic [1:0]  psel, pready, pslverr;
    logic        penable, pwrite;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [63:0] prdata;

    int          cfg_wait = 0;
    bit          cfg_err = 0, cfg_hang = 0, cfg_noise = 0;
    logic [31:0] tgt_rdata [2];
    int          acc_cnt = 0;

    int checks = 0;
    int errors = 0;

    int          mon_setups = 0, mon_access = 0, mon_bad = 0;
    logic [1:0]  cap_psel = '0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        cap_write = 1'b0;
    logic [3:0]  cap_strb = '0;
    logic [2:0]  cap_prot = '0;

    caliptra_axil2apb_bridge dut (
        .core_clk      (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .m_apb_paddr   (paddr),
        .m_apb_psel    (psel),
        .m_apb_penable (penable),
        .m_apb_pwrite  (pwrite),
        .m_apb_pwdata  (pwdata),
        .m_apb_pstrb   (pstrb),
        .m_apb_pprot   (pprot),
        .m_apb_prdata  (prdata),
        .m_apb_pready  (pready),
        .m_apb_pslverr (pslverr)
    );

    always #5 clk = ~clk;

    // APB targets: the selected one waits cfg_wait access cycles; unselected
    // ones optionally drive garbage ready/error that must be ignored.
    always @(posedge clk) acc_cnt <= (penable && psel != 2'b00) ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = 2'b00;
        pslverr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (psel[i]) begin
                pready[i]  = penable && !cfg_hang && (acc_cnt >= cfg_wait);
                pslverr[i] = penable && !cfg_hang && (acc_cnt >= cfg_wait) && cfg_err;
            end else begin
                pready[i]  = cfg_noise;
                pslverr[i] = cfg_noise;
            end
        end
    end

    assign prdata = {tgt_rdata[1], tgt_rdata[0]};

    // APB observer: captures each SETUP phase and flags protocol breaks.
    always @(negedge clk) begin
        if (psel != 2'b00 && !penable) begin
            mon_setups <= mon_setups + 1;
            cap_psel   <= psel;
            cap_addr   <= paddr;
            cap_write  <= pwrite;
            cap_wdata  <= pwdata;
            cap_strb   <= pstrb;
            cap_prot   <= pprot;
        end
        if (penable) begin
            mon_access <= mon_access + 1;
            if ({psel, paddr, pwrite, pwdata, pstrb, pprot} !==
                {cap_psel, cap_addr, cap_write, cap_wdata, cap_strb, cap_prot})
                mon_bad <= mon_bad + 1;
        end
        if ((penable && psel == 2'b00) || (psel == 2'b11))
            mon_bad <= mon_bad + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                paddr, psel, penable, pwrite, pwdata, pstrb, pprot};
    endfunction

    // Transaction-level expectation from the decode rules and target behaviour.
    function automatic void model(input bit wr, input logic [31:0] addr,
                                  output logic [1:0] resp, output logic [31:0] rd,
                                  output int lat, output logic [1:0] pse, output int acc);
        int t;
        t  = addr[16] ? 1 : 0;
        rd = '0;
        if (addr[31:17] != 15'd0) begin
            resp = 2'b11; lat = 1; pse = 2'b00; acc = 0;
        end else begin
            pse  = 2'b01 << t;
            acc  = cfg_hang ? TMO : cfg_wait + 1;
            lat  = 2 + acc;
            resp = (cfg_hang || cfg_err) ? 2'b10 : 2'b00;
            if (!wr && resp == 2'b00) rd = tgt_rdata[t];
        end
    endfunction

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, input int bdly,
                          input logic [1:0] e_resp, input logic [31:0] e_rdata, input int e_lat,
                          input logic [1:0] e_psel, input int e_acc);
        int n, lat, s0, a0, b0;
        s0 = mon_setups; a0 = mon_access; b0 = mon_bad;
        if (wr) begin
            awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
            awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arprot = prot; arvalid = 1'b1;
        end
        n = 0;
        forever begin
            #1;
            if ((wr ? awready : arready) || n >= 20) break;
            @(negedge clk);
            n++;
        end
        chk("grant", wr ? awready : arready, 1);
        if (wr) chk("wready_with_awready", {wready, arready}, 2'b10);
        @(negedge clk);
        chk("ready_pulse", {awready, wready, arready}, 3'b000);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        lat = 1;
        while (!(wr ? bvalid : rvalid) && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("resp", wr ? bresp : rresp, e_resp);
        if (!wr) chk("rdata", rdata, e_rdata);
        for (int d = 0; d < bdly; d++) begin
            @(negedge clk);
            chk("resp_hold", {bvalid, rvalid, (wr ? bresp : rresp), (wr ? 32'h0 : rdata)},
                {wr, !wr, e_resp, (wr ? 32'h0 : e_rdata)});
        end
        if (wr) bready = 1'b1; else rready = 1'b1;
        @(negedge clk);
        chk("resp_clear", {bvalid, rvalid}, 2'b00);
        bready = 1'b0; rready = 1'b0;
        chk("setup_count", mon_setups - s0, (e_psel != 2'b00) ? 1 : 0);
        chk("access_cycles", mon_access - a0, e_acc);
        chk("apb_protocol", mon_bad - b0, 0);
        if (e_psel != 2'b00)
            chk("apb_setup", {cap_psel, cap_addr, cap_write, cap_strb, cap_prot,
                              (wr ? cap_wdata : 32'h0)},
                {e_psel, addr, wr, (wr ? strb : 4'h0), prot, (wr ? data : 32'h0)});
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          wt;
        bit          err;
        bit          hang;
        bit          noise;
        logic [31:0] prdata;
        int          bdly;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        int          e_lat;
        logic [1:0]  e_psel;
        int          e_acc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, g, t, el, ea, bd;
        logic [1:0]  er, ep;
        logic [31:0] erd, a, d;
        bit          w;

        //           wr    addr          wdata         strb   prot  wt err hg nz prdata        bdly resp   rdata         lat  psel   acc
        vecs[0] = '{1'b1, 32'h0001_0004, 32'hA5A5_5A5A, 4'hF, 3'd0, 0, 0, 0, 0, 32'h0,         0, 2'b00, 32'h0,         3,   2'b10, 1};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3'd2, 3, 0, 0, 0, 32'h1234_5678, 0, 2'b00, 32'h1234_5678, 6,   2'b01, 4};
        vecs[2] = '{1'b0, 32'h0003_0000, 32'h0,         4'h0, 3'd0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 2'b11, 32'h0,         1,   2'b00, 0};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'h1122_3344, 4'h5, 3'd1, 1, 1, 0, 0, 32'h0,        10, 2'b10, 32'h0,         4,   2'b01, 2};
        vecs[4] = '{1'b0, 32'h0001_0008, 32'h0,         4'h0, 3'd0, 0, 1, 0, 0, 32'h55AA_55AA, 0, 2'b10, 32'h0,         3,   2'b10, 1};
        vecs[5] = '{1'b0, 32'h0001_FFFC, 32'h0,         4'h0, 3'd3, 2, 0, 0, 1, 32'hCAFE_F00D, 3, 2'b00, 32'hCAFE_F00D, 5,   2'b10, 3};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 3'd0, 0, 0, 0, 0, 32'h0,         0, 2'b11, 32'h0,         1,   2'b00, 0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'h3, 3'd5, 0, 0, 0, 1, 32'h0,         2, 2'b00, 32'h0,         3,   2'b01, 1};
        vecs[8] = '{1'b1, 32'h0001_0040, 32'h1357_9BDF, 4'hF, 3'd0, 0, 0, 1, 0, 32'h0,         0, 2'b10, 32'h0,         257, 2'b10, 255};
        vecs[9] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 3'd0, 0, 0, 1, 0, 32'h8765_4321, 0, 2'b10, 32'h0,         257, 2'b01, 255};

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        tgt_rdata[0] = 32'h0; tgt_rdata[1] = 32'h0;

        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous write and read held valid: grants must alternate W,R,W,R.
        awaddr = 32'h0000_0004; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awprot = 3'd0;
        araddr = 32'h0001_0000; arprot = 3'd0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        g = 0; n = 0;
        while (g < 4 && n < 200) begin
            #1;
            if (awready || arready) begin
                chk("arb_order", {awready, arready}, (g % 2 == 0) ? 2'b10 : 2'b01);
                g++;
            end
            @(negedge clk);
            n++;
        end
        chk("arb_grants", g, 4);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (6) @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cfg_wait = vecs[i].wt; cfg_err = vecs[i].err;
            cfg_hang = vecs[i].hang; cfg_noise = vecs[i].noise;
            t = vecs[i].addr[16] ? 1 : 0;
            tgt_rdata[t]     = vecs[i].prdata;
            tgt_rdata[1 - t] = ~vecs[i].prdata;
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                   vecs[i].bdly, vecs[i].e_resp, vecs[i].e_rdata, vecs[i].e_lat,
                   vecs[i].e_psel, vecs[i].e_acc);
        end

        // Reset asserted mid-ACCESS: outputs clear at once, no response follows.
        cfg_hang = 1; cfg_wait = 0; cfg_err = 0; cfg_noise = 0;
        awaddr = 32'h0000_0040; wdata = 32'h2468_ACE0; wstrb = 4'hF; awprot = 3'd0;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        forever begin
            #1;
            if (awready || n >= 20) break;
            @(negedge clk);
            n++;
        end
        chk("rst_grant", awready, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!penable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_in_access", penable, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_hang = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_resp_after_reset", {bvalid, rvalid, psel, penable}, 5'b0);
        end
        tgt_rdata[0] = 32'h0A0B_0C0D; tgt_rdata[1] = 32'h1A1B_1C1D;
        model(1'b0, 32'h0000_0044, er, erd, el, ep, ea);
        do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'd1, 1, er, erd, el, ep, ea);

        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom & 32'h0001_FFFC;
            if ($urandom_range(0, 5) == 0) a = a | (32'h0002_0000 << $urandom_range(0, 14));
            d = $urandom;
            cfg_wait  = $urandom_range(0, 4);
            cfg_err   = ($urandom_range(0, 7) == 0);
            cfg_noise = 1'($urandom_range(0, 1));
            cfg_hang  = 1'b0;
            tgt_rdata[0] = $urandom;
            tgt_rdata[1] = $urandom;
            bd = $urandom_range(0, 3);
            model(w, a, er, erd, el, ep, ea);
            do_txn(w, a, d, 4'($urandom), 3'($urandom), bd, er, erd, el, ep, ea);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
